// File: rtl/mem_access_pkg.sv
// Shared types for the memory access stage:
// bus request/response bundles, latched op and FSM states.
package mem_access_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        store;
    msize_t      size;
    logic        unsigned_;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DRAIN
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store strobe/shifted data, load extraction
// and extension, misalign detect. Ports: size/uns/lane/wdata/bus_data in.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  msize_t      size,
  input  logic        uns,
  input  logic [2:0]  lane,
  input  logic [63:0] wdata,
  input  logic [63:0] bus_data,
  output logic [7:0]  strobe,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata,
  output logic        misalign
);

  logic [63:0] raw;
  logic [7:0]  mask;

  assign raw      = bus_data >> {lane, 3'b000};
  assign wdata_sh = wdata << {lane, 3'b000};
  assign strobe   = mask << lane;

  always_comb begin
    mask     = 8'h00;
    rdata    = '0;
    misalign = 1'b0;
    unique case (1'b1)
      (size == MSIZE1): begin
        mask  = 8'h01;
        rdata = {{56{raw[7] & ~uns}}, raw[7:0]};
      end
      (size == MSIZE2): begin
        mask     = 8'h03;
        misalign = lane[0];
        rdata    = {{48{raw[15] & ~uns}}, raw[15:0]};
      end
      (size == MSIZE4): begin
        mask     = 8'h0F;
        misalign = |lane[1:0];
        rdata    = {{32{raw[31] & ~uns}}, raw[31:0]};
      end
      default: begin
        mask     = 8'hFF;
        misalign = |lane;
        rdata    = raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one load/store per handshake onto the data bus.
// Ports: req_* op in, resp_* result out, dreq/dresp bus, flush, busy.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int CHECK_ALIGN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  msize_t          req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            busy,
  output dbus_req_t       dreq,
  input  dbus_resp_t      dresp
);

  localparam bit CHK = (CHECK_ALIGN != 0);

  mem_state_t  state_q, state_d;
  mem_op_t     in_op, op_q;
  logic [63:0] rdata_q, la_wdata, la_rdata, sel_wdata;
  logic [7:0]  la_strobe;
  logic [2:0]  sel_lane;
  msize_t      sel_size;
  logic        sel_uns, la_mis, mis_q;
  logic        idle, accept, bad, data_ok, dv;
  logic        unused;

  assign unused  = dresp.addr_ok;
  assign data_ok = dresp.data_ok;
  assign idle    = (state_q == S_IDLE);
  assign accept  = req_valid & idle & ~flush;
  assign bad     = CHK & la_mis;
  assign dv      = (state_q == S_REQ) | (state_q == S_DRAIN);

  assign in_op = '{store:     req_store,
                   size:      req_size,
                   unsigned_: req_unsigned,
                   addr:      req_addr,
                   wdata:     req_wdata};

  // Idle: examine the incoming op for misalignment.
  // Otherwise: the latched op feeds dreq and load extraction.
  assign sel_size  = idle ? in_op.size      : op_q.size;
  assign sel_uns   = idle ? in_op.unsigned_ : op_q.unsigned_;
  assign sel_lane  = idle ? in_op.addr[2:0] : op_q.addr[2:0];
  assign sel_wdata = idle ? in_op.wdata     : op_q.wdata;

  mem_lane_align u_align (
    .size     (sel_size),
    .uns      (sel_uns),
    .lane     (sel_lane),
    .wdata    (sel_wdata),
    .bus_data (dresp.data),
    .strobe   (la_strobe),
    .wdata_sh (la_wdata),
    .rdata    (la_rdata),
    .misalign (la_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept) state_d = bad ? S_RESP : S_REQ;
      S_REQ:
        if (data_ok)    state_d = flush ? S_IDLE : S_RESP;
        else if (flush) state_d = S_DRAIN;
      S_DRAIN:
        if (data_ok) state_d = S_IDLE;
      default:
        if (resp_ready | flush) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = idle;
    busy       = ~idle;
    resp_valid = (state_q == S_RESP);
    dreq       = '0;
    if (dv) begin
      dreq.valid  = 1'b1;
      dreq.addr   = op_q.addr;
      dreq.size   = op_q.size;
      dreq.strobe = la_strobe;
      dreq.data   = la_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= in_op;
        mis_q   <= bad;
        rdata_q <= '0;
      end
      if ((state_q == S_REQ) && data_ok && !flush)
        rdata_q <= op_q.store ? '0 : la_rdata;
    end
  end

  assign resp_rdata    = rdata_q;
  assign resp_misalign = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases then random ops
// against a byte-lane arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  msize_t      req_size;
  logic [63:0] req_addr, req_wdata;
  logic        flush, resp_valid, resp_ready, resp_misalign, busy;
  logic [63:0] resp_rdata;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_store     (req_store),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .busy          (busy),
    .dreq          (dreq),
    .dresp         (dresp)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_strobe(input int sz,
                                            input logic [2:0] k);
    logic [15:0] m;
    m = ((16'd1 << (1 << sz)) - 16'd1) << k;
    return m[7:0];
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] bd,
                                           input int sz, input logic un,
                                           input logic [2:0] k);
    logic [63:0] raw, mask, v;
    int nb;
    nb  = 1 << sz;
    raw = bd >> (8 * k);
    if (nb == 8) return raw;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = raw & mask;
    if (!un && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_op(input logic st, input int sz, input logic un,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] bd, input int waits,
                        input int hold);
    int n;
    logic mis;
    logic [63:0] er;
    n   = 1 << sz;
    mis = (a % n) != 0;
    er  = (st || mis) ? 64'd0 : exp_load(bd, sz, un, a[2:0]);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = msize_t'(sz);
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    tick();
    req_valid = 1'b0;
    chk("ready_low", 64'(req_ready), 64'd0);
    if (mis) begin
      chk("mis_noreq", 64'(dreq.valid), 64'd0);
      chk("mis_valid", 64'(resp_valid), 64'd1);
      chk("mis_flag", 64'(resp_misalign), 64'd1);
      chk("mis_rdata", resp_rdata, 64'd0);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        chk("dreq_valid", 64'(dreq.valid), 64'd1);
        chk("dreq_addr", dreq.addr, a);
        chk("dreq_size", 64'(dreq.size), 64'(sz));
        chk("dreq_strobe", 64'(dreq.strobe), 64'(exp_strobe(sz, a[2:0])));
        chk("dreq_data", dreq.data, wd << (8 * a[2:0]));
        chk("resp_early", 64'(resp_valid), 64'd0);
        dresp.data    = (i == waits) ? bd : rnd64();
        dresp.data_ok = (i == waits);
        tick();
      end
      dresp.data_ok = 1'b0;
      chk("resp_valid", 64'(resp_valid), 64'd1);
      chk("resp_rdata", resp_rdata, er);
      chk("resp_mis", 64'(resp_misalign), 64'd0);
      chk("dreq_drop", 64'(dreq.valid), 64'd0);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, er);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("done_valid", 64'(resp_valid), 64'd0);
    chk("done_ready", 64'(req_ready), 64'd1);
    chk("done_noreq", 64'(dreq.valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_unsigned = 1'b0;
    req_size = MSIZE1; req_addr = '0; req_wdata = '0;
    flush = 1'b0; resp_ready = 1'b0; dresp = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_dreq", 64'(|dreq), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mis", 64'(resp_misalign), 64'd0);

    // dword store, one wait cycle -> resp three cycles after accept
    run_op(1'b1, 3, 1'b0, 64'h80001000, 64'h1122334455667788, 64'd0, 1, 0);
    // signed and unsigned byte loads from lane 3
    run_op(1'b0, 0, 1'b0, 64'h80001003, 64'd0, 64'h0000000080000000, 0, 0);
    run_op(1'b0, 0, 1'b1, 64'h80001003, 64'd0, 64'h0000000080000000, 0, 0);
    // half store in top lanes, four wait cycles
    run_op(1'b1, 1, 1'b0, 64'h80001006, 64'h000000000000BEEF, 64'd0, 4, 0);
    // misaligned word load
    run_op(1'b0, 2, 1'b0, 64'h80001002, 64'd0, 64'd0, 0, 0);

    // flush with req_valid in idle: not accepted
    req_valid = 1'b1; flush = 1'b1; req_size = MSIZE8;
    req_addr = 64'h80001008;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_noreq", 64'(dreq.valid), 64'd0);

    // flush one cycle into REQ, data_ok three cycles later
    req_valid = 1'b1; req_store = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("fl_req", 64'(dreq.valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("fl_drain_valid", 64'(dreq.valid), 64'd1);
      chk("fl_no_resp", 64'(resp_valid), 64'd0);
      chk("fl_busy", 64'(busy), 64'd1);
      dresp.data_ok = (c == 2);
      dresp.data = rnd64();
      tick();
    end
    dresp.data_ok = 1'b0;
    chk("fl_end_noreq", 64'(dreq.valid), 64'd0);
    chk("fl_end_noresp", 64'(resp_valid), 64'd0);
    chk("fl_end_idle", 64'(req_ready), 64'd1);

    // result held five cycles with resp_ready low
    run_op(1'b0, 2, 1'b0, 64'h80001004, 64'd0, 64'h89ABCDEF01234567, 2, 5);

    // misaligned op leaves misalign set, then reset mid-REQ
    run_op(1'b0, 1, 1'b0, 64'h80001001, 64'd0, 64'd0, 0, 0);
    req_valid = 1'b1; req_size = MSIZE4; req_addr = 64'h80001010;
    tick();
    req_valid = 1'b0;
    chk("rstm_req", 64'(dreq.valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstm_dreq", 64'(|dreq), 64'd0);
    chk("rstm_rvalid", 64'(resp_valid), 64'd0);
    chk("rstm_busy", 64'(busy), 64'd0);
    chk("rstm_rdata", resp_rdata, 64'd0);
    chk("rstm_mis", 64'(resp_misalign), 64'd0);
    dresp.data_ok = 1'b1;
    tick();
    dresp.data_ok = 1'b0;
    chk("late_ok_noresp", 64'(resp_valid), 64'd0);
    chk("late_ok_idle", 64'(busy), 64'd0);

    // random ops, mostly aligned
    for (int r = 0; r < 40; r++) begin
      int sz;
      logic [63:0] a;
      logic [2:0] k;
      sz = int'($urandom % 4);
      k  = 3'($urandom);
      if (($urandom % 5) != 0) k = k & ~3'((1 << sz) - 1);
      a = 64'h80002000 + 64'(($urandom % 64) * 8) + 64'(k);
      run_op(1'($urandom), sz, 1'($urandom), a, rnd64(), rnd64(),
             int'($urandom % 4), int'($urandom % 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
